// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Package : alu_pkg
// Opcode map, controller state encoding and opcode legality helper.
// Rev     : 1.0
//==============================================================================
package alu_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_ADD2 = 2;
    localparam int unsigned OP_SUB2 = 3;
    localparam int unsigned OP_ADD4 = 4;
    localparam int unsigned OP_ADD5 = 5;
    localparam int unsigned OP_AND  = 6;
    localparam int unsigned OP_OR   = 7;
    localparam int unsigned OP_AND2 = 8;
    localparam int unsigned OP_OR2  = 9;
    localparam int unsigned OP_SLL  = 10;
    localparam int unsigned OP_SRL  = 11;
    localparam int unsigned OP_ONE  = 12;
    localparam int unsigned OP_ONE2 = 13;
    localparam int unsigned OP_NE   = 14;
    localparam int unsigned OP_EQ   = 15;
    localparam int unsigned OP_LE   = 16;
    localparam int unsigned OP_LT   = 17;
    localparam int unsigned OP_GE   = 18;
    localparam int unsigned OP_GT   = 19;
    localparam int unsigned OP_ZERO = 20;
    localparam int unsigned OP_ZER2 = 21;
    localparam int unsigned OP_ZER3 = 22;
    localparam int unsigned OP_LT2  = 23;
    localparam int unsigned OP_LT3  = 24;
    localparam int unsigned OP_MUL  = 25;
    localparam int unsigned OP_SRA  = 26;
    localparam int unsigned OP_LAST = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal(input int unsigned op);
        return op <= OP_LAST;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
//==============================================================================
// Module : alu_mul_iter
// Iterative shift-add multiplier, one partial product per cycle.
// Rev    : 1.0
//==============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_acc  <= '0;
            r_a_sh <= {{WIDTH{1'b0}}, a};
            r_b_sh <= b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= w_acc_nxt;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == c_last_cnt) begin
                r_busy <= 1'b0;
            end
        end
    end

    // product is the accumulator value after the step taken this cycle,
    // so it is final on the cycle done is high.
    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == c_last_cnt);
    assign product = w_acc_nxt;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
//==============================================================================
// Module : alu_pipe
// Registered ALU with valid/ready handshake and an iterative multiplier.
// Rev    : 1.0
//==============================================================================
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic [WIDTH-1:0]   r_c;
    logic               r_ovf;
    logic               r_ill;

    logic [31:0]        w_op;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_cy;
    logic               w_ill;
    logic               w_is_mul;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    assign w_op     = 32'(opcode);
    assign w_sh     = b[SHW-1:0];
    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_is_mul = (w_op == OP_MUL);

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ill = !is_legal(w_op);
        case (w_op)
            OP_ADD, OP_ADD2, OP_ADD4, OP_ADD5: {w_cy, w_res} = w_sum;
            OP_SUB, OP_SUB2: begin
                w_res = a - b;
                w_cy  = (a < b);
            end
            OP_AND, OP_AND2:           w_res = a & b;
            OP_OR, OP_OR2:             w_res = a | b;
            OP_SLL:                    w_res = a << w_sh;
            OP_SRL:                    w_res = a >> w_sh;
            OP_ONE, OP_ONE2:           w_res = WIDTH'(1);
            OP_NE:                     w_res = WIDTH'(a != b);
            OP_EQ:                     w_res = WIDTH'(a == b);
            OP_LE:                     w_res = WIDTH'(a <= b);
            OP_LT, OP_LT2, OP_LT3:     w_res = WIDTH'(a < b);
            OP_GE:                     w_res = WIDTH'(a >= b);
            OP_GT:                     w_res = WIDTH'(a > b);
            OP_ZERO, OP_ZER2, OP_ZER3: w_res = '0;
            OP_MUL:                    w_res = '0;
            OP_SRA:                    w_res = $unsigned($signed(a) >>> w_sh);
            default:                   w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept && w_is_mul) w_state_nxt = MUL;
            MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = DONE;
                end else if (!w_mul_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == IDLE) && (!r_valid || out_ready);
        w_accept    = in_valid && w_in_ready;
        w_mul_start = w_accept && w_is_mul;
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // Result register loads only on a new result; otherwise it holds until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_valid <= 1'b1;
            r_c     <= w_res;
            r_ovf   <= w_cy;
            r_ill   <= w_ill;
        end else if (w_mul_done) begin
            r_valid <= 1'b1;
            r_c     <= w_prod[WIDTH-1:0];
            r_ovf   <= |w_prod[2*WIDTH-1:WIDTH];
            r_ill   <= 1'b0;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign c         = r_c;
    assign zero      = (r_c == '0);
    assign ovf       = r_ovf;
    assign illegal   = r_ill;

endmodule
`default_nettype wire
